// File: rtl/bidi_pkg.sv
// Shared constants for the bidirectional register bank and its counter cells.
package bidi_pkg;

    localparam int   DEFAULT_BUS_WIDTH = 16;

    localparam logic RW_READ    = 1'b0;
    localparam logic RW_WRITE   = 1'b1;
    localparam logic COUNT_UP   = 1'b0;
    localparam logic COUNT_DOWN = 1'b1;

endpackage

// File: rtl/bidi_counter_cell.sv
// One register of the bank: synchronous reset, parallel load, up/down count
// with wrap or saturate, and a combinational flag when a count hits its limit.
module bidi_counter_cell
    import bidi_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_BUS_WIDTH,
    parameter int COUNT_EN = 1,
    parameter int SATURATE = 0
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             COUNT,
    input  logic             DOWN,
    output logic [WIDTH-1:0] VALUE,
    output logic             LIMIT_HIT
);

    logic             count_active;
    logic             at_limit;
    logic [WIDTH-1:0] next_count;

    // Load has priority, so a count in a load cycle never reaches the limit flag.
    always_comb begin
        count_active = (COUNT_EN != 0) && COUNT && !LOAD;
        at_limit     = (DOWN == COUNT_DOWN) ? (VALUE == '0) : (VALUE == '1);
        if ((SATURATE != 0) && at_limit) begin
            next_count = VALUE;
        end else if (DOWN == COUNT_DOWN) begin
            next_count = VALUE - WIDTH'(1);
        end else begin
            next_count = VALUE + WIDTH'(1);
        end
    end

    assign LIMIT_HIT = count_active && at_limit;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            VALUE <= '0;
        end else if (LOAD) begin
            VALUE <= LOAD_DATA;
        end else if (count_active) begin
            VALUE <= next_count;
        end
    end

endmodule

// File: rtl/bidi_register_bank.sv
// DEPTH counter registers sharing one registered tri-state data bus.
// Defining BIDI_REGBANK_DEBUG_EN adds a registered DEBUG_OUT snapshot of all registers.
module bidi_register_bank
    import bidi_pkg::*;
#(
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int COUNT_EN   = 1,
    parameter int SATURATE   = 0
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic                  RW,
    input  logic                  ENABLE,
    input  logic                  COUNT,
    input  logic                  DOWN,
    inout  wire  [BUS_WIDTH-1:0]  DATA,
    output logic                  ZERO,
    output logic                  CARRY
`ifdef BIDI_REGBANK_DEBUG_EN
    ,
    output logic [DEPTH*BUS_WIDTH-1:0] DEBUG_OUT
`endif
);

    logic [BUS_WIDTH-1:0] cell_value [DEPTH];
    logic [DEPTH-1:0]     cell_limit;
    logic [BUS_WIDTH-1:0] selected_value;
    logic                 addr_valid;
    logic                 bus_load;
    logic                 drive_q;
    logic [BUS_WIDTH-1:0] drive_data_q;

    // Out-of-range addresses match no cell, so the selected value falls back to zero.
    always_comb begin
        addr_valid     = 32'(ADDR) < 32'(DEPTH);
        bus_load       = ENABLE && (RW == RW_READ);
        selected_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(ADDR) == 32'(i)) begin
                selected_value = cell_value[i];
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic hit;
        assign hit = (32'(ADDR) == 32'(i));

        bidi_counter_cell #(
            .WIDTH    (BUS_WIDTH),
            .COUNT_EN (COUNT_EN),
            .SATURATE (SATURATE)
        ) u_cell (
            .CLOCK     (CLOCK),
            .RESET     (RESET),
            .LOAD      (hit && bus_load),
            .LOAD_DATA (DATA),
            .COUNT     (hit && COUNT),
            .DOWN      (DOWN),
            .VALUE     (cell_value[i]),
            .LIMIT_HIT (cell_limit[i])
        );
    end

    assign ZERO = addr_valid && (selected_value == '0);

    // The bus shows the value held before the edge; an unknown RW leaves drive_q unknown,
    // which turns the tri-state mux into an all-x bus.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            drive_q      <= 1'b0;
            drive_data_q <= '0;
            CARRY        <= 1'b0;
        end else begin
            drive_q      <= ENABLE && (RW == RW_WRITE);
            drive_data_q <= selected_value;
            CARRY        <= |cell_limit;
        end
    end

    assign DATA = drive_q ? drive_data_q : {BUS_WIDTH{1'bz}};

`ifdef BIDI_REGBANK_DEBUG_EN
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            DEBUG_OUT <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                DEBUG_OUT[i*BUS_WIDTH +: BUS_WIDTH] <= cell_value[i];
            end
        end
    end
`endif

endmodule

// File: doc/bidi_register_bank.md
Name: bidi_register_bank

Overview:
- Multi-entry successor to the single bus register: DEPTH addressable registers of BUS_WIDTH bits share one tri-state data bus.
- Each entry supports bus load, bus drive, and up/down counting.
- Counting can wrap or saturate, with a carry/borrow pulse.
- Used as the processor's general register file, or as a PC/SP pair.

Parameters:
- BUS_WIDTH, 16, width of each register and of DATA
- DEPTH, 4, number of registers (>=2)
- ADDR_WIDTH, 2, width of ADDR; must be >= clog2(DEPTH)
- COUNT_EN, 1, 0 removes all count logic (COUNT/DOWN ignored, CARRY tied 0)
- SATURATE, 0, 1 = count clamps at max/0 instead of wrapping

Ports:
- CLOCK  input  1  system clock, all state on rising edge
- RESET  input  1  synchronous reset, active-high
- ADDR  input  ADDR_WIDTH  selects the register for bus and count ops
- RW  input  1  0 = read from bus into register, 1 = write register onto bus
- ENABLE  input  1  bus access enable
- COUNT  input  1  count the addressed register this cycle
- DOWN  input  1  0 = increment, 1 = decrement (valid with COUNT)
- DATA  inout  BUS_WIDTH  shared data bus
- ZERO  output  1  combinational: addressed register == 0 (0 if ADDR out of range)
- CARRY  output  1  registered one-cycle pulse on wrap/borrow or saturation hit

Behaviour:
- Reset (RESET=1 at edge):
  - All registers are cleared to 0.
  - The DATA driver is released (z) and CARRY is 0.
  - Reset overrides load and count in the same cycle.
- Priority per addressed entry:
  - RESET, then bus load (ENABLE=1, RW=0), then count (COUNT=1 and COUNT_EN).
  - Non-addressed entries hold their value.
- Load: DATA is sampled at the edge into reg[ADDR]. Count is suppressed that cycle and CARRY is 0.
- Bus drive:
  - If ENABLE=1 and RW=1 at edge N, DATA is driven from N+1 with the reg[ADDR] value present before edge N.
  - Driving is registered (1-cycle latency).
  - If ENABLE=0 or RW=0 at edge N, DATA is z from N+1.
  - RW=x/z with ENABLE=1: bus is driven all-x, and registers hold.
- Count with simultaneous drive: the bus shows the pre-count value, and the register updates at the same edge.
- Wrap (SATURATE=0):
  - Up from 2^BUS_WIDTH-1 goes to 0.
  - Down from 0 goes to 2^BUS_WIDTH-1.
  - Either case sets CARRY=1 for exactly the next cycle.
- Saturate (SATURATE=1):
  - Up at max holds max; down at 0 holds 0.
  - CARRY pulses on each blocked attempt.
- CARRY is 0 in every cycle not following a wrap or saturation event.
- Out-of-range ADDR (>= DEPTH):
  - Load and count are ignored.
  - Drive outputs all zeros.
  - ZERO=0.
- ADDR may change every cycle. There are no hidden states and no multi-cycle operations.

Optional Feature:
- Macro BIDI_REGBANK_DEBUG_EN.
- When defined:
  - Adds output port DEBUG_OUT [DEPTH*BUS_WIDTH-1:0], the concatenation of all registers with reg[0] in the LSBs.
  - DEBUG_OUT is registered, so it reflects state after the previous edge, and is 0 in reset.
- When undefined: the port and its logic are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package bidi_pkg holds:
  - constants RW_READ=1'b0, RW_WRITE=1'b1, COUNT_UP=1'b0, COUNT_DOWN=1'b1
  - default BUS_WIDTH
- Sub-module bidi_counter_cell: one register with reset/load/count/wrap-or-saturate logic and a carry output, instantiated DEPTH times.
- The bank owns address decode, the bus driver, ZERO and the CARRY register.

Test Plan:
- Reset then read-back:
  - Drive DATA=16'hBEEF, ENABLE=1, RW=0, ADDR=2 for one cycle, release the bus.
  - Then ENABLE=1, RW=1, ADDR=2 → DATA=16'hBEEF from the next cycle.
  - Then ENABLE=0 → DATA=z one cycle later.
- Wrap:
  - Load 16'hFFFF into reg1, COUNT=1, DOWN=0 → reg1=0, CARRY=1 for one cycle.
  - Second COUNT → reg1=1, CARRY=0.
- Borrow:
  - reg0=0, COUNT=1, DOWN=1 → reg0=16'hFFFF, CARRY=1.
  - With SATURATE=1 → reg0 stays 0, CARRY=1, ZERO=1.
- Priority:
  - Same cycle ENABLE=1, RW=0, DATA=16'h0010, COUNT=1, ADDR=3 → reg3=16'h0010 (no increment).
  - Add RESET=1 → reg3=0.
- Drive+count:
  - reg2=16'h0007, ENABLE=1, RW=1, COUNT=1 → bus shows 16'h0007 next cycle, reg2=16'h0008.
  - Other registers unchanged.
- Out-of-range/debug:
  - DEPTH=3, ADDR=3, write → DATA=0, ZERO=0, registers unchanged.
  - With BIDI_REGBANK_DEBUG_EN: DEBUG_OUT equals {reg2,reg1,reg0} one cycle after each update.
